// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types and constants for the round-robin stream arbiter
package rr_arb_pkg;

  // Arbiter is either searching for a new winner or locked onto one source mid-packet
  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Width of each per-source completed-packet counter
  localparam int STAT_CNT_WIDTH = 32;

endpackage

// File: rtl/rr_prio_pick.sv
// rtl/rr_prio_pick.sv - rotating-priority encoder: first set request at or above ptr, with wrap
module rr_prio_pick import rr_arb_pkg::*; #(
  parameter  int NUM_IN   = 4,
  localparam int ID_WIDTH = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0]   i_req,
  input  logic [ID_WIDTH-1:0] i_ptr,
  output logic                o_found,
  output logic [ID_WIDTH-1:0] o_grant
);

  // ptr is always below NUM_IN, so a single conditional subtract is enough to wrap
  function automatic logic [ID_WIDTH-1:0] wrap_idx(input logic [ID_WIDTH-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_IN) s = s - NUM_IN;
    return s[ID_WIDTH-1:0];
  endfunction

  // Scan offsets from farthest to nearest so the nearest requester from ptr wins
  always_comb begin
    o_found = 1'b0;
    o_grant = '0;
    for (int off = NUM_IN - 1; off >= 0; off--) begin
      if (i_req[wrap_idx(i_ptr, off)]) begin
        o_found = 1'b1;
        o_grant = wrap_idx(i_ptr, off);
      end
    end
  end

endmodule

// File: rtl/rr_stream_arbiter.sv
// rtl/rr_stream_arbiter.sv - packet-locked round-robin stream merger; RR_STREAM_ARBITER_STATS_EN adds per-source packet counters
module rr_stream_arbiter import rr_arb_pkg::*; #(
  parameter  int NUM_IN     = 4,
  parameter  int DATA_WIDTH = 32,
  localparam int ID_WIDTH   = $clog2(NUM_IN)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN-1:0]            in_valid,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]            in_last,
  output logic [NUM_IN-1:0]            in_ready,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_last,
  output logic [ID_WIDTH-1:0]          out_id,
  input  logic                         out_ready
`ifdef RR_STREAM_ARBITER_STATS_EN
  ,
  output logic [NUM_IN*STAT_CNT_WIDTH-1:0] stat_pkt_cnt
`endif
);

  localparam logic [ID_WIDTH-1:0] LAST_IDX = ID_WIDTH'(NUM_IN - 1);

  arb_state_e            r_state;
  logic [ID_WIDTH-1:0]   r_grant;
  logic [ID_WIDTH-1:0]   r_ptr;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_last;
  logic [ID_WIDTH-1:0]   r_out_id;

  logic                  w_found;
  logic [ID_WIDTH-1:0]   w_pick;
  logic [ID_WIDTH-1:0]   w_sel;
  logic                  w_sel_ok;
  logic                  w_can_load;
  logic [NUM_IN-1:0]     w_ready;
  logic                  w_accept;
  logic                  w_sel_last;
  logic [ID_WIDTH-1:0]   w_ptr_next;
  logic [DATA_WIDTH-1:0] w_data_arr [NUM_IN];

  for (genvar k = 0; k < NUM_IN; k++) begin : g_unpack
    assign w_data_arr[k] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_prio_pick #(.NUM_IN(NUM_IN)) u_pick (
    .i_req   (in_valid),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_grant (w_pick)
  );

  // While locked the held winner keeps the grant even if its valid drops
  assign w_sel      = (r_state == ARB_LOCKED) ? r_grant : w_pick;
  assign w_sel_ok   = (r_state == ARB_LOCKED) || w_found;
  assign w_can_load = !r_out_valid || out_ready;
  assign w_sel_last = in_last[w_sel];
  assign w_accept   = in_valid[w_sel] && w_ready[w_sel];
  assign w_ptr_next = (w_sel == LAST_IDX) ? '0 : w_sel + 1'b1;

  // One-hot ready to the current winner only, when the output slot can take a beat
  always_comb begin
    w_ready = '0;
    if (!rst && w_sel_ok && w_can_load) w_ready[w_sel] = 1'b1;
  end

  assign in_ready  = w_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_id    = r_out_id;

  // Grant FSM plus the single output register slot
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_grant     <= '0;
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_id    <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data_arr[w_sel];
      r_out_last  <= w_sel_last;
      r_out_id    <= w_sel;
      if (w_sel_last) begin
        r_state <= ARB_IDLE;
        r_ptr   <= w_ptr_next;
      end else begin
        r_state <= ARB_LOCKED;
        r_grant <= w_sel;
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef RR_STREAM_ARBITER_STATS_EN
  logic [STAT_CNT_WIDTH-1:0] r_stat_cnt [NUM_IN];

  // Count accepted end-of-packet beats per source, wrapping naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_IN; k++) r_stat_cnt[k] <= '0;
    end else if (w_accept && w_sel_last) begin
      r_stat_cnt[w_sel] <= r_stat_cnt[w_sel] + 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_IN; k++) begin : g_stat
    assign stat_pkt_cnt[k*STAT_CNT_WIDTH +: STAT_CNT_WIDTH] = r_stat_cnt[k];
  end
`endif

endmodule
